// File: rtl/ptp_b.sv
// ptp_b: narrow/wide width bridge with two independent handshake channels.
// Assembler packs IN_W beats LSB-first into OUT_W words; disassembler splits.
//
// Ports:
//   clock, reset_i (async, active low), clear_i (sync flush, active high)
//   a_valid_i/a_ready_o/a_data_i : narrow beats into the assembler
//   w_valid_o/w_ready_i/w_data_o : assembled wide words out
//   d_valid_i/d_ready_o/d_data_i : wide words into the disassembler
//   b_valid_o/b_ready_i/b_data_o : narrow beats out
//   a_cnt_o : beats held in the partial word, err_o : timeout pulse
//
// Optional build macro PTP_B_TIMEOUT_EN: drop a partial word after
// TIMEOUT_CYC idle cycles and pulse err_o. Without it err_o is tied low.

module ptp_b #(
   parameter int IN_W        = 8,
   parameter int OUT_W       = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                           clock,
   input  logic                           reset_i,
   input  logic                           clear_i,
   input  logic                           a_valid_i,
   output logic                           a_ready_o,
   input  logic [IN_W-1:0]                a_data_i,
   output logic                           w_valid_o,
   input  logic                           w_ready_i,
   output logic [OUT_W-1:0]               w_data_o,
   input  logic                           d_valid_i,
   output logic                           d_ready_o,
   input  logic [OUT_W-1:0]               d_data_i,
   output logic                           b_valid_o,
   input  logic                           b_ready_i,
   output logic [IN_W-1:0]                b_data_o,
   output logic [$clog2(OUT_W/IN_W)-1:0]  a_cnt_o,
   output logic                           err_o
);

   localparam int BEATS = OUT_W / IN_W;
   localparam int CW    = $clog2(BEATS);

   if ((OUT_W % IN_W) != 0 || BEATS < 2 || TIMEOUT_CYC < 1) begin : g_param_chk
      $error("ptp_b: need OUT_W = k*IN_W with k >= 2 and TIMEOUT_CYC >= 1");
   end

   typedef enum logic {FILL, HOLD} a_state_t;
   typedef enum logic {IDLE, SEND} d_state_t;

   // ---------------- assembler ----------------

   a_state_t a_st_q, a_st_d;
   logic     a_fire, w_fire, a_last, a_drop;

   assign a_fire = a_valid_i & a_ready_o;
   assign w_fire = w_valid_o & w_ready_i;
   assign a_last = (a_cnt_o == CW'(BEATS - 1));

   always_ff @(posedge clock or negedge reset_i) begin
      if (!reset_i) a_st_q <= FILL;
      else          a_st_q <= a_st_d;
   end

   always_comb begin
      a_st_d = a_st_q;
      if (clear_i) begin
         a_st_d = FILL;
      end else begin
         unique case (a_st_q)
            FILL: if (a_fire && a_last) a_st_d = HOLD;
            HOLD: if (w_fire)           a_st_d = FILL;
         endcase
      end
   end

   // While a word is held, a new beat is only taken alongside the word
   // handshake so the next word starts without a bubble.
   always_comb begin
      a_ready_o = 1'b1;
      w_valid_o = 1'b0;
      unique case (a_st_q)
         FILL: ;
         HOLD: begin
            w_valid_o = 1'b1;
            a_ready_o = w_ready_i;
         end
      endcase
   end

   // a_cnt_o is zero in HOLD, so a beat accepted there lands in slice 0.
   always_ff @(posedge clock or negedge reset_i) begin
      if (!reset_i) begin
         a_cnt_o  <= '0;
         w_data_o <= '0;
      end else if (clear_i || a_drop) begin
         a_cnt_o <= '0;
      end else if (a_fire) begin
         for (int k = 0; k < BEATS; k++) begin
            if (a_cnt_o == CW'(k)) w_data_o[k*IN_W +: IN_W] <= a_data_i;
         end
         if (a_st_q == FILL && a_last) a_cnt_o <= '0;
         else                          a_cnt_o <= a_cnt_o + CW'(1);
      end
   end

`ifdef PTP_B_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] idle_q;
   logic          err_q;
   logic          idle_run;

   assign idle_run = (a_st_q == FILL) && (a_cnt_o != '0) && !a_fire;
   assign a_drop   = idle_run && (idle_q == TW'(TIMEOUT_CYC - 1));
   assign err_o    = err_q;

   always_ff @(posedge clock or negedge reset_i) begin
      if (!reset_i) begin
         idle_q <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (clear_i || a_fire) begin
            idle_q <= '0;
         end else if (a_drop) begin
            idle_q <= '0;
            err_q  <= 1'b1;
         end else if (idle_run) begin
            idle_q <= idle_q + TW'(1);
         end
      end
   end
`else
   assign a_drop = 1'b0;
   assign err_o  = 1'b0;
`endif

   // ---------------- disassembler ----------------

   d_state_t         d_st_q, d_st_d;
   logic [OUT_W-1:0] d_sh_q;
   logic [CW-1:0]    b_idx_q;
   logic             d_fire, b_fire, b_last;

   assign d_fire   = d_valid_i & d_ready_o;
   assign b_fire   = b_valid_o & b_ready_i;
   assign b_last   = (b_idx_q == CW'(BEATS - 1));
   assign b_data_o = d_sh_q[IN_W-1:0];

   always_ff @(posedge clock or negedge reset_i) begin
      if (!reset_i) d_st_q <= IDLE;
      else          d_st_q <= d_st_d;
   end

   always_comb begin
      d_st_d = d_st_q;
      if (clear_i) begin
         d_st_d = IDLE;
      end else begin
         unique case (d_st_q)
            IDLE: if (d_fire) d_st_d = SEND;
            SEND: if (b_fire && b_last) d_st_d = d_fire ? SEND : IDLE;
         endcase
      end
   end

   // The last beat handshake frees the word register in the same cycle.
   always_comb begin
      d_ready_o = 1'b1;
      b_valid_o = 1'b0;
      unique case (d_st_q)
         IDLE: ;
         SEND: begin
            b_valid_o = 1'b1;
            d_ready_o = b_ready_i & b_last;
         end
      endcase
   end

   // The low slice of the shift register is the outgoing beat.
   always_ff @(posedge clock or negedge reset_i) begin
      if (!reset_i) begin
         d_sh_q  <= '0;
         b_idx_q <= '0;
      end else if (!clear_i) begin
         if (d_fire) begin
            d_sh_q  <= d_data_i;
            b_idx_q <= '0;
         end else if (b_fire && !b_last) begin
            d_sh_q  <= {{IN_W{1'b0}}, d_sh_q[OUT_W-1:IN_W]};
            b_idx_q <= b_idx_q + CW'(1);
         end
      end
   end

endmodule

// File: doc/ptp_b.md
Name: ptp_b

Overview:
- Parametrised successor to the 8-to-32 assembler; bridges the Manchester Baby's OUT_W-bit RAM word to a narrow IN_W-bit external pin bus.
- Two independent channels:
  - Assembler (read path): narrow beats in, wide word out.
  - Disassembler (write path): wide word in, narrow beats out.
- Both channels use valid/ready handshakes, and one clock drives everything.

Parameters:
IN_W, 8, narrow beat width in bits
OUT_W, 32, wide word width; must be an integer multiple of IN_W with OUT_W/IN_W >= 2 (elaboration error otherwise)
TIMEOUT_CYC, 255, idle cycles before a partial word is dropped (used only with the optional feature)

Ports:
clock  input  1  system clock, rising edge
reset_i  input  1  asynchronous, active-low reset
clear_i  input  1  synchronous flush of both channels, active high
a_valid_i  input  1  assembler beat valid
a_ready_o  output  1  assembler beat ready
a_data_i  input  IN_W  assembler beat
w_valid_o  output  1  assembled word valid
w_ready_i  input  1  assembled word ready
w_data_o  output  OUT_W  assembled word
d_valid_i  input  1  disassembler word valid
d_ready_o  output  1  disassembler word ready
d_data_i  input  OUT_W  word to split
b_valid_o  output  1  split beat valid
b_ready_i  input  1  split beat ready
b_data_o  output  IN_W  split beat
a_cnt_o  output  clog2(BEATS)  beats held in the partial word
err_o  output  1  timeout pulse

Behaviour:
- BEATS = OUT_W/IN_W.
- Handshake fires on a cycle where valid and ready are both high at the rising clock edge.
- Reset (reset_i low, asynchronous):
  - w_valid_o=0, b_valid_o=0, a_cnt_o=0, err_o=0.
  - w_data_o=0, b_data_o=0, internal registers=0.
  - a_ready_o=1, d_ready_o=1.
- Assembler FSM, states FILL and HOLD:
  - FILL:
    - a_ready_o=1.
    - Each accepted beat k (k=a_cnt_o) is written to w_data_o[k*IN_W +: IN_W], LSB-first; a_cnt_o then increments.
    - Accepting beat BEATS-1 moves to HOLD with a_cnt_o=0; w_valid_o=1 from the next cycle.
  - HOLD:
    - w_valid_o=1 and w_data_o held stable until w_ready_i.
    - a_ready_o = w_ready_i.
    - On the word handshake the FSM returns to FILL. A simultaneous beat is stored as beat 0 of the next word (a_cnt_o=1), so there is no bubble.
  - Latency: the word is visible one cycle after its last beat is accepted.
  - Sustained throughput is one beat per cycle.
- Disassembler FSM, states IDLE and SEND:
  - IDLE:
    - d_ready_o=1.
    - On a word handshake the word is latched, b_data_o = d_data_i[IN_W-1:0], b_valid_o=1 next cycle, and the FSM moves to SEND.
  - SEND:
    - d_ready_o=0.
    - Each beat handshake advances to the next slice, LSB-first.
    - On the handshake of beat BEATS-1:
      - if d_valid_i is also high, d_ready_o is allowed high in that cycle and the new word loads back-to-back;
      - otherwise the FSM returns to IDLE and b_valid_o=0.
- Channels are fully independent; simultaneous activity on both is legal.
- clear_i (synchronous):
  - Both FSMs return to FILL/IDLE; a_cnt_o=0, w_valid_o=0, b_valid_o=0.
  - Any handshake in the same cycle is discarded.
  - Data registers are not cleared.
- Reset asserted mid-word drops all partial state immediately. After release, the first beat lands in slice 0.
- Valid outputs never drop without a handshake, except through reset or clear_i.
- Data on a valid output is held stable while waiting for ready.

Optional Feature:
- Macro: PTP_B_TIMEOUT_EN.
- When defined:
  - An idle counter runs while the assembler is in FILL with a_cnt_o>0 and no beat is accepted.
  - It resets on every accepted beat.
  - On reaching TIMEOUT_CYC, the partial word is discarded (a_cnt_o=0) and err_o pulses high for exactly one cycle.
  - The next beat lands in slice 0.
- When undefined:
  - No counter logic is built; err_o is tied to 0.
  - A partial word is held indefinitely.

Test Plan:
All scenarios use IN_W=8, OUT_W=32.
1. Beats 0x11,0x22,0x33,0x44 on consecutive cycles with w_ready_i=1 -> w_valid_o high one cycle after the 4th beat, w_data_o=0x44332211; a_cnt_o steps 1,2,3,0.
2. Assembler backpressure: w_ready_i=0 for 5 cycles after the word completes -> w_data_o is stable, a_ready_o=0; raising w_ready_i together with beat 0xAA gives a_cnt_o=1, then the next word has 0xAA in bits [7:0].
3. Disassembler: word 0xDEADBEEF, with b_ready_i toggling 1,0,1,1,1 -> beats 0xEF,0xBE,0xAD,0xDE in order, no beat lost or repeated; a second word queued on d_valid_i is accepted in the cycle of the last beat handshake.
4. clear_i after 2 assembler beats and mid-disassembly -> a_cnt_o=0, b_valid_o=0 next cycle; next beats 0x01..0x04 give 0x04030201.
5. reset_i pulsed low asynchronously (between clock edges) mid-word -> all outputs at reset values immediately; after release the word assembles from slice 0.
6. PTP_B_TIMEOUT_EN with TIMEOUT_CYC=4: 1 beat, then 4 idle cycles -> err_o high for one cycle, a_cnt_o=0. Without the macro, err_o stays 0 and a_cnt_o stays 1.
